pll_lock_seq: RTL



---
 rtl/pll_seq_pkg.sv | 19 +
 rtl/sync_ff2.sv | 25 ++
 rtl/pll_lock_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock/reset sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_CNT_W          = 16;

    localparam int unsigned STAT_W   = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop bit synchronizer for asynchronous level inputs, sync reset to 0.
module sync_ff2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// Sequences PLL reset, waits for a stable lock, then releases the system reset.
module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              reinit,
    input  logic              locked,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic [STAT_W-1:0] loss_count,
    output logic [STAT_W-1:0] retry_count
);

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic              lock_s;
    pll_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pll_rst_q, pll_rst_d;
    logic              sys_rst_q, sys_rst_d;
    logic              ready_q, ready_d;
    logic [STAT_W-1:0] loss_q, retry_q;
    logic              inc_loss_c, inc_retry_c;

    sync_ff2 u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (lock_s)
    );

    // State, step counter and output flops.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and counter update; reinit overrides every other transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        inc_loss_c  = 1'b0;
        inc_retry_c = 1'b0;
        if (reinit) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == PLL_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = RESET_PLL;
                        cnt_d       = '0;
                        inc_retry_c = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d    = WAIT_LOCK;
                        inc_loss_c = 1'b1;
                    end
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the flops update with the transition.
    always_comb begin
        pll_rst_d = (state_d == RESET_PLL);
        ready_d   = (state_d == RUN);
        sys_rst_d = (state_d != RUN);
    end

    // Saturating lock-loss and retry statistics.
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q  <= '0;
            retry_q <= '0;
        end else begin
            if (inc_loss_c && (loss_q != STAT_MAX)) begin
                loss_q <= loss_q + STAT_W'(1);
            end
            if (inc_retry_c && (retry_q != STAT_MAX)) begin
                retry_q <= retry_q + STAT_W'(1);
            end
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign loss_count  = loss_q;
    assign retry_count = retry_q;

endmodule
